// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encodings,
// sequential PC step and the default reset vector.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HAZARD   = 2'd2,
    ST_REDIRECT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequences PC updates around hazards, memory waits
// and branch redirects. Optional stall/flush counters under FETCH_PERF_CNT_EN.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned WAIT_LIMIT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cur_pc,
  input  logic        hz_detect,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        pc_load,
  output logic [31:0] next_pc,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        imem_timeout,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic [1:0]  state_o
);

  localparam int unsigned      CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  fetch_state_e     state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      seq_pc;

  assign seq_pc = cur_pc + PC_STEP;

  // State register and bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state and combinational outputs
  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
    imem_req    = 1'b0;
    pc_load     = 1'b0;
    next_pc     = seq_pc;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;

    case (state_q)
      ST_RUN, ST_HAZARD: begin
        if (branch_taken) begin
          pc_load     = 1'b1;
          next_pc     = branch_target;
          if_id_flush = 1'b1;
          state_d     = ST_REDIRECT;
        end else if (hz_detect) begin
          state_d = ST_HAZARD;
        end else if (state_q == ST_HAZARD) begin
          state_d = ST_RUN;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            pc_load     = 1'b1;
            if_id_write = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        imem_req = 1'b1;
        // A branch in the ack cycle itself is the latest and wins
        if (branch_taken) begin
          pend_vld_d = 1'b1;
          pend_pc_d  = branch_target;
        end
        if (imem_ack) begin
          pc_load = 1'b1;
          if (pend_vld_d) begin
            next_pc     = pend_pc_d;
            if_id_flush = 1'b1;
            pend_vld_d  = 1'b0;
            state_d     = ST_REDIRECT;
          end else begin
            if_id_write = 1'b1;
            state_d     = ST_RUN;
          end
        end else begin
          wait_cnt_d = (wait_cnt_q == LIMIT) ? wait_cnt_q : CNT_W'(wait_cnt_q + 1'b1);
          if (wait_cnt_d == LIMIT) timeout_d = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if_id_flush = 1'b1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (reset) begin
      imem_req    = 1'b0;
      pc_load     = 1'b0;
      next_pc     = RESET_VECTOR;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
    end
  end

  assign state_o      = reset ? ST_RUN : state_q;
  assign imem_timeout = timeout_q & ~reset;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Wrapping stall and flush event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q == ST_HAZARD || state_q == ST_MEM_WAIT) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_d == ST_REDIRECT) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a behavioural model predicts each
// cycle's outputs, a monitor compares them against the DUT on the falling edge.
module tb_fetch_controller;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          LIMIT = 16;

  logic        clk;
  logic        reset;
  logic [31:0] cur_pc;
  logic        hz_detect;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic        imem_ack;
  logic        pc_load;
  logic [31:0] next_pc;
  logic        if_id_write;
  logic        if_id_flush;
  logic        imem_timeout;
  logic [1:0]  state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  fetch_controller #(.RESET_VECTOR(RV), .WAIT_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cur_pc       (cur_pc),
    .hz_detect    (hz_detect),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .pc_load      (pc_load),
    .next_pc      (next_pc),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .imem_timeout (imem_timeout),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .state_o      (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        req;
    logic        load;
    logic [31:0] npc;
    logic        wr;
    logic        fl;
    logic        to;
    logic [1:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: what the fetch unit is currently doing
  bit          m_hazard, m_waiting, m_redirect, m_pend, m_timeout;
  logic [31:0] m_pend_pc;
  int          m_wait_run;
  logic [31:0] pc_track;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_hazard = 0; m_waiting = 0; m_redirect = 0; m_pend = 0; m_timeout = 0;
    m_pend_pc = '0; m_wait_run = 0;
  endtask

  // Drive one cycle of inputs, predict the outputs, advance the model
  task automatic cycle(input bit rst, input logic [31:0] pc, input bit hz,
                       input bit br, input logic [31:0] tgt, input bit ack);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; cur_pc = pc; hz_detect = hz;
    branch_taken = br; branch_target = tgt; imem_ack = ack;
    e = '0;
    if (rst) begin
      e.npc = RV;
      model_clear();
    end else begin
      e.npc = pc + 32'd4;
      e.to  = m_timeout;
      e.st  = m_redirect ? 2'd3 : m_hazard ? 2'd2 : m_waiting ? 2'd1 : 2'd0;
      if (m_redirect) begin
        e.fl = 1; m_redirect = 0;
      end else if (m_waiting) begin
        e.req = 1;
        if (br) begin m_pend = 1; m_pend_pc = tgt; end
        if (ack) begin
          e.load = 1; m_waiting = 0; m_wait_run = 0;
          if (m_pend) begin
            e.npc = m_pend_pc; e.fl = 1; m_pend = 0; m_redirect = 1;
          end else begin
            e.wr = 1;
          end
        end else begin
          m_wait_run++;
          if (m_wait_run >= LIMIT) m_timeout = 1;
        end
      end else if (br) begin
        e.load = 1; e.npc = tgt; e.fl = 1; m_hazard = 0; m_redirect = 1;
      end else if (hz) begin
        m_hazard = 1;
      end else if (m_hazard) begin
        m_hazard = 0;
      end else begin
        e.req = 1;
        if (ack) begin e.load = 1; e.wr = 1; end
        else m_waiting = 1;
      end
    end
    sb_q.push_back(e);
    if (e.load) pc_track = e.npc;
  endtask

  // Monitor: compare the DUT against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("imem_req",     32'(imem_req),     32'(e.req));
        chk("pc_load",      32'(pc_load),      32'(e.load));
        chk("next_pc",      next_pc,           e.npc);
        chk("if_id_write",  32'(if_id_write),  32'(e.wr));
        chk("if_id_flush",  32'(if_id_flush),  32'(e.fl));
        chk("imem_timeout", 32'(imem_timeout), 32'(e.to));
        chk("state_o",      32'(state_o),      32'(e.st));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; cur_pc = '0; hz_detect = 0; branch_taken = 0;
    branch_target = '0; imem_ack = 0;
    model_clear();
    pc_track = '0;

    // Reset with noisy inputs
    cycle(1, 32'h0000_1234, 0, 1, 32'h0000_0999, 1);
    cycle(1, 32'h0000_1234, 1, 0, 32'h0, 1);

    // Sequential fetch with ack held high
    repeat (3) cycle(0, 32'h100, 0, 0, 32'h0, 1);

    // Two-cycle hazard
    cycle(0, 32'h104, 1, 0, 32'h0, 1);
    cycle(0, 32'h104, 1, 0, 32'h0, 1);
    cycle(0, 32'h104, 0, 0, 32'h0, 1);
    cycle(0, 32'h104, 0, 0, 32'h0, 1);

    // Branch in RUN, noisy inputs during the redirect cycle
    cycle(0, 32'h108, 0, 1, 32'h400, 0);
    cycle(0, 32'h400, 1, 1, 32'hDEAD_BEEC, 1);

    // Branch while waiting, ack three cycles later
    cycle(0, 32'h400, 0, 0, 32'h0, 0);
    cycle(0, 32'h400, 0, 1, 32'h800, 0);
    cycle(0, 32'h400, 0, 0, 32'h0, 0);
    cycle(0, 32'h400, 0, 0, 32'h0, 0);
    cycle(0, 32'h400, 0, 0, 32'h0, 1);
    cycle(0, 32'h800, 0, 0, 32'h0, 0);

    // Latest pending branch wins, including one in the ack cycle
    cycle(0, 32'h800, 0, 0, 32'h0, 0);
    cycle(0, 32'h800, 0, 1, 32'hA00, 0);
    cycle(0, 32'h800, 0, 1, 32'hB00, 1);
    cycle(0, 32'hB00, 0, 0, 32'h0, 0);

    // PC wrap
    cycle(0, 32'hFFFF_FFFC, 0, 0, 32'h0, 1);

    // Timeout: ack withheld, sticky after ack, cleared by reset
    cycle(0, 32'h200, 0, 0, 32'h0, 0);
    repeat (LIMIT + 3) cycle(0, 32'h200, 0, 0, 32'h0, 0);
    cycle(0, 32'h200, 0, 0, 32'h0, 1);
    repeat (3) cycle(0, 32'h204, 0, 0, 32'h0, 1);
    cycle(1, 32'h204, 0, 0, 32'h0, 0);
    cycle(0, 32'h204, 0, 0, 32'h0, 1);

    // Reset mid-wait, ack during reset ignored
    cycle(0, 32'h300, 0, 0, 32'h0, 0);
    cycle(0, 32'h300, 0, 1, 32'h500, 0);
    cycle(1, 32'h300, 0, 0, 32'h0, 1);
    cycle(0, 32'h300, 0, 0, 32'h0, 0);
    cycle(0, 32'h300, 0, 0, 32'h0, 1);

    // Randomized traffic
    pc_track = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      bit          r_rst, r_hz, r_br, r_ack;
      logic [31:0] r_tgt, r_pc;
      r_rst = ($urandom_range(99) < 2);
      r_hz  = ($urandom_range(99) < 20);
      r_br  = ($urandom_range(99) < 15);
      r_ack = ($urandom_range(99) < ((i % 300) < 60 ? 3 : 55));
      r_tgt = $urandom & 32'hFFFF_FFFC;
      r_pc  = ($urandom_range(99) < 3) ? 32'hFFFF_FFFC : pc_track;
      cycle(r_rst, r_pc, r_hz, r_br, r_tgt, r_ack);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_VECTOR, 32'h0000_0000, value driven on next_pc while reset is high.
REQ-002 SHALL have parameter WAIT_LIMIT, 16, number of consecutive MEM_WAIT cycles before imem_timeout sets.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous and active-high reset.
REQ-005 SHALL have port cur_pc, input, 32, current program counter register value.
REQ-006 SHALL have port hz_detect, input, 1, load-use hazard from the hazard unit (1 = stall).
REQ-007 SHALL have ports branch_taken (input, 1) and branch_target (input, 32): the redirect request and its target.
REQ-008 SHALL have port imem_req, output, 1, instruction memory fetch request.
REQ-009 SHALL have port imem_ack, input, 1, fetch complete; counts only when imem_req=1.
REQ-010 SHALL have ports pc_load (output, 1; 1 = PC takes next_pc this edge) and next_pc (output, 32).
REQ-011 SHALL have ports if_id_write (output, 1), if_id_flush (output, 1) and imem_timeout (output, 1, sticky).
REQ-012 SHALL have port state_o, output, 2, current FSM state encoding.

Function
REQ-013 SHALL implement FSM states RUN=0, MEM_WAIT=1, HAZARD=2, REDIRECT=3; outputs are combinational from state and inputs.
REQ-014 SHALL apply branch_taken > hz_detect > imem_ack as the priority order in RUN and HAZARD.
REQ-015 RUN: branch_taken SHALL give pc_load=1, next_pc=branch_target, if_id_flush=1, next state REDIRECT.
REQ-016 RUN: hz_detect SHALL give pc_load=0, if_id_write=0, imem_req=0, next state HAZARD.
REQ-017 RUN: otherwise SHALL drive imem_req=1; on ack, pc_load=1, if_id_write=1, next_pc=cur_pc+4 and stay in RUN; with no ack, go to MEM_WAIT.
REQ-018 HAZARD SHALL hold pc_load=0, if_id_write=0 and imem_req=0 while hz_detect=1, and go to RUN when hz_detect=0.
REQ-019 MEM_WAIT SHALL keep imem_req=1 with pc_load=0 until ack.
REQ-020 MEM_WAIT: branch_taken SHALL latch branch_target into a pending register (latest wins) and leave imem_req unaffected.
REQ-021 MEM_WAIT ack with a pending redirect SHALL give pc_load=1, next_pc=pending target, if_id_flush=1, clear the pending redirect, and go to REDIRECT.
REQ-022 MEM_WAIT ack with no pending redirect SHALL give the sequential update (REQ-017) and go to RUN.
REQ-023 REDIRECT SHALL last exactly one cycle with imem_req=0, pc_load=0 and if_id_flush=1, then go to RUN; inputs are ignored.
REQ-024 cur_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 A wait counter SHALL count MEM_WAIT cycles and clear on ack; reaching WAIT_LIMIT SHALL set imem_timeout, which holds until reset; the FSM is not altered.
REQ-026 When not in REQ-015/021, next_pc SHALL equal cur_pc+4.

Reset
REQ-027 While reset=1 SHALL force state RUN, pc_load=0, next_pc=RESET_VECTOR, imem_req=0, if_id_write=0, if_id_flush=0, and clear the pending redirect, wait counter and imem_timeout.
REQ-028 Reset asserted mid-MEM_WAIT SHALL abandon the fetch; an ack arriving during reset SHALL be ignored.

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined, SHALL add 32-bit outputs stall_cnt (+1 per HAZARD or MEM_WAIT cycle) and flush_cnt (+1 per cycle entering REDIRECT), both wrapping, cleared by reset.
REQ-030 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent, with function otherwise identical.

Structure
REQ-031 SHALL place the state encodings, PC_STEP=4 and the default RESET_VECTOR in a shared package, fetch_pkg.
REQ-032 SHALL be a single module; no sub-modules.

Verification
REQ-033 Reset, then cur_pc=0x100 with ack held high -> next_pc=0x104, pc_load=1 every cycle, state_o=0.
REQ-034 hz_detect high for 2 cycles in RUN -> 2 cycles of pc_load=0 and if_id_write=0 in HAZARD, then RUN.
REQ-035 branch_taken with target 0x400 in RUN -> next_pc=0x400 and flush for 2 cycles (RUN edge plus REDIRECT).
REQ-036 In MEM_WAIT, branch to 0x800 then ack 3 cycles later -> next_pc=0x800 on the ack cycle, then REDIRECT.
REQ-037 cur_pc=0xFFFF_FFFC with ack -> next_pc=0x0; ack withheld 16 cycles -> imem_timeout=1 until reset.
